// File: rtl/encoder_4to2_queue_pkg.sv
// Shared types and constants for the 4-to-2 request queue encoder.
// Holds the FSM state type, widths and small bit helpers.
package encoder_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount4(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/encoder_4to2_queue_if.sv
// Request/response bundle between the request sources, the encoder and its consumer.
interface encoder_4to2_queue_if;
  import encoder_pkg::*;

  logic             enable;
  logic [N_REQ-1:0] in;
  logic             out_ready;
  logic [IDX_W-1:0] out;
  logic             out_valid;
  logic [N_REQ-1:0] pending;
  logic [CNT_W-1:0] count;

  modport master (
    output enable, in, out_ready,
    input  out, out_valid, pending, count
  );

  modport slave (
    input  enable, in, out_ready,
    output out, out_valid, pending, count
  );

endinterface

// File: rtl/encoder_4to2_queue_prio_enc4.sv
// Combinational fixed-priority encoder: lowest set bit wins (bit 0 highest).
module prio_enc4
  import encoder_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_any = |i_vec;
    o_idx = '0;
    if (i_vec[0])      o_idx = 2'd0;
    else if (i_vec[1]) o_idx = 2'd1;
    else if (i_vec[2]) o_idx = 2'd2;
    else if (i_vec[3]) o_idx = 2'd3;
  end

endmodule

// File: rtl/encoder_4to2_queue.sv
// Coalescing request queue: latches request strobes into a pending set and
// presents them one index at a time, lowest index first, with backpressure.
module encoder_4to2_queue
  import encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  encoder_4to2_queue_if.slave  bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [N_REQ-1:0] r_pend;
  logic [IDX_W-1:0] r_out;
  logic [CNT_W-1:0] r_count;

  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_pend_next;
  logic [N_REQ-1:0] w_rem;
  logic [IDX_W-1:0] w_next_out;
  logic [IDX_W-1:0] w_pend_idx;
  logic [IDX_W-1:0] w_rem_idx;
  logic             w_pend_any;
  logic             w_rem_any;

  prio_enc4 u_pend_sel (
    .i_vec (r_pend),
    .o_idx (w_pend_idx),
    .o_any (w_pend_any)
  );

  prio_enc4 u_rem_sel (
    .i_vec (w_rem),
    .o_idx (w_rem_idx),
    .o_any (w_rem_any)
  );

  // A new strobe ORs in after the clear, so a re-request of the bit being accepted survives.
  always_comb begin
    w_clr        = '0;
    w_rem        = r_pend & ~onehot(r_out);
    w_next_state = r_state;
    w_next_out   = r_out;
    if (r_state == BUSY && bus.out_ready) begin
      w_clr = onehot(r_out);
    end
    w_pend_next = (r_pend & ~w_clr) | (bus.enable ? bus.in : '0);

    case (r_state)
      IDLE: begin
        if (w_pend_any) begin
          w_next_state = BUSY;
          w_next_out   = w_pend_idx;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          if (w_rem_any) begin
            w_next_out = w_rem_idx;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_out   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_pend  <= w_pend_next;
      r_out   <= w_next_out;
      r_count <= popcount4(w_pend_next);
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = (r_state == BUSY);
  assign bus.pending   = r_pend;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_encoder_4to2_queue.sv
// Directed self-checking bench for encoder_4to2_queue with hand-computed expectations.
module tb_encoder_4to2_queue;

  logic clk;
  logic rst_n;
  int unsigned n_chk;
  int unsigned n_err;
  int unsigned n_emit;

  encoder_4to2_queue_if bus ();

  encoder_4to2_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted handshakes so coalescing and reset discard can be checked.
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) n_emit++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic v, input logic [1:0] o,
                              input logic [3:0] p, input logic [2:0] c);
    chk({tag, ".valid"}, {7'd0, bus.out_valid}, {7'd0, v});
    chk({tag, ".out"},   {6'd0, bus.out},       {6'd0, o});
    chk({tag, ".pend"},  {4'd0, bus.pending},   {4'd0, p});
    chk({tag, ".count"}, {5'd0, bus.count},     {5'd0, c});
  endtask

  task automatic expect_idle(input string tag, input logic [3:0] p, input logic [2:0] c);
    chk({tag, ".valid"}, {7'd0, bus.out_valid}, 8'd0);
    chk({tag, ".pend"},  {4'd0, bus.pending},   {4'd0, p});
    chk({tag, ".count"}, {5'd0, bus.count},     {5'd0, c});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    n_emit = 0;
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.in = 4'b1111;
    bus.out_ready = 1'b1;
    step();
    step();
    expect_state("reset", 1'b0, 2'd0, 4'b0000, 3'd0);

    rst_n = 1'b1;
    bus.enable = 1'b0;
    bus.in = 4'b0000;
    step();
    expect_state("post_reset", 1'b0, 2'd0, 4'b0000, 3'd0);

    // Single request, two-cycle latency
    bus.enable = 1'b1;
    bus.in = 4'b0100;
    bus.out_ready = 1'b1;
    step();
    expect_idle("single.e0", 4'b0100, 3'd1);
    bus.in = 4'b0000;
    step();
    expect_state("single.e1", 1'b1, 2'd2, 4'b0100, 3'd1);
    step();
    expect_state("single.e2", 1'b0, 2'd2, 4'b0000, 3'd0);

    // Priority and back-to-back
    bus.in = 4'b1011;
    step();
    expect_idle("b2b.e0", 4'b1011, 3'd3);
    bus.in = 4'b0000;
    step();
    expect_state("b2b.i0", 1'b1, 2'd0, 4'b1011, 3'd3);
    step();
    expect_state("b2b.i1", 1'b1, 2'd1, 4'b1010, 3'd2);
    step();
    expect_state("b2b.i3", 1'b1, 2'd3, 4'b1000, 3'd1);
    step();
    expect_state("b2b.idle", 1'b0, 2'd3, 4'b0000, 3'd0);

    // Backpressure holds out even when a higher-priority request lands
    bus.out_ready = 1'b0;
    bus.in = 4'b0110;
    step();
    expect_idle("bp.e0", 4'b0110, 3'd2);
    bus.in = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_state("bp.hold", 1'b1, 2'd1, 4'b0111, 3'd3);
    end
    bus.in = 4'b0000;
    bus.out_ready = 1'b1;
    step();
    expect_state("bp.i0", 1'b1, 2'd0, 4'b0101, 3'd2);
    step();
    expect_state("bp.i2", 1'b1, 2'd2, 4'b0100, 3'd1);
    step();
    expect_state("bp.idle", 1'b0, 2'd2, 4'b0000, 3'd0);

    // Re-request of the index being accepted wins over the clear
    bus.in = 4'b1000;
    step();
    expect_idle("rereq.e0", 4'b1000, 3'd1);
    bus.in = 4'b0000;
    step();
    expect_state("rereq.first", 1'b1, 2'd3, 4'b1000, 3'd1);
    bus.in = 4'b1000;
    step();
    expect_state("rereq.accept", 1'b0, 2'd3, 4'b1000, 3'd1);
    bus.in = 4'b0000;
    step();
    expect_state("rereq.again", 1'b1, 2'd3, 4'b1000, 3'd1);
    step();
    expect_state("rereq.idle", 1'b0, 2'd3, 4'b0000, 3'd0);

    // Enable gating and coalescing
    bus.enable = 1'b0;
    bus.in = 4'b1111;
    bus.out_ready = 1'b0;
    step();
    expect_idle("gate.off", 4'b0000, 3'd0);
    n_emit = 0;
    bus.enable = 1'b1;
    bus.in = 4'b0010;
    step();
    expect_idle("coal.e0", 4'b0010, 3'd1);
    step();
    expect_state("coal.e1", 1'b1, 2'd1, 4'b0010, 3'd1);
    step();
    expect_state("coal.e2", 1'b1, 2'd1, 4'b0010, 3'd1);
    bus.in = 4'b0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_idle("coal.drain", 4'b0000, 3'd0);
    end
    chk("coal.emits", n_emit[7:0], 8'd1);

    // Reset mid-operation discards everything
    bus.out_ready = 1'b0;
    bus.in = 4'b1110;
    step();
    expect_idle("rst.e0", 4'b1110, 3'd3);
    bus.in = 4'b0000;
    step();
    expect_state("rst.busy", 1'b1, 2'd1, 4'b1110, 3'd3);
    rst_n = 1'b0;
    bus.in = 4'b1111;
    bus.out_ready = 1'b1;
    step();
    expect_state("rst.mid", 1'b0, 2'd0, 4'b0000, 3'd0);
    rst_n = 1'b1;
    bus.in = 4'b0000;
    n_emit = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_state("rst.after", 1'b0, 2'd0, 4'b0000, 3'd0);
    end
    chk("rst.emits", n_emit[7:0], 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
